// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
//   Shared definitions for the 12-bit serial sequence detector.
//   - seq_state_t : FSM state, Sk = longest matched pattern prefix of length k
//   - SEQ_PATTERN : the detected pattern, compared first bit = MSB
//   - SEQ_LEN     : pattern length in bits
//   - SEQ_CNT_W   : width of the optional saturating detection counter
// -----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int unsigned SEQ_LEN   = 12;
  localparam int unsigned SEQ_CNT_W = 8;

  localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 12'b1110_1101_1011;

  typedef enum logic [3:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10,
    S11 = 4'd11,
    S12 = 4'd12
  } seq_state_t;

endpackage : seq_det_pkg

// File: rtl/seq_det_counter.sv
// -----------------------------------------------------------------------------
// seq_det_counter
//   Saturating event counter used by the detector when SEQ_DET_CNT_EN is set.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high clear
//     inc   : count one event on this edge
//     cnt   : current count, holds at all-ones
// -----------------------------------------------------------------------------
module seq_det_counter
  import seq_det_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [SEQ_CNT_W-1:0] cnt
);

  localparam logic [SEQ_CNT_W-1:0] CNT_MAX = '1;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its sources.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : seq_det_counter

// File: rtl/day_12_sequence_detector.sv
// -----------------------------------------------------------------------------
// day_12_sequence_detector
//   Serial pattern detector. Samples one bit of x_i per rising clock edge and
//   raises det_o for one cycle whenever the last 12 sampled bits equal
//   1110_1101_1011 (first sampled bit = MSB). Overlapping matches count.
//
//   Ports:
//     clk       : rising-edge clock
//     reset     : synchronous, active-high; clears all partial matches
//     x_i       : serial data bit
//     det_o     : registered (Moore) detection pulse, high while in S12
//     det_cnt_o : 8-bit saturating detection count (SEQ_DET_CNT_EN only)
//
//   Build option:
//     SEQ_DET_CNT_EN : adds det_cnt_o and its saturating counter.
// -----------------------------------------------------------------------------
module day_12_sequence_detector
  import seq_det_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x_i,
  output logic                 det_o
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [SEQ_CNT_W-1:0] det_cnt_o
`endif
);

  seq_state_t state;
  seq_state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Mismatch targets are the KMP fallbacks: a stray 1 after
  // "111" keeps "111" matched (S3); everything else that breaks the pattern
  // falls back to S0. S12 behaves like S2 because the pattern ends in its own
  // leading "11".
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // state_next unassigned, which would infer a latch.
    state_next = S0;
    unique case (state)
      S0:      state_next = x_i ? S1  : S0;
      S1:      state_next = x_i ? S2  : S0;
      S2:      state_next = x_i ? S3  : S0;
      S3:      state_next = x_i ? S3  : S4;
      S4:      state_next = x_i ? S5  : S0;
      S5:      state_next = x_i ? S6  : S0;
      S6:      state_next = x_i ? S3  : S7;
      S7:      state_next = x_i ? S8  : S0;
      S8:      state_next = x_i ? S9  : S0;
      S9:      state_next = x_i ? S3  : S10;
      S10:     state_next = x_i ? S11 : S0;
      S11:     state_next = x_i ? S12 : S0;
      S12:     state_next = x_i ? S3  : S0;
      default: state_next = S0;
    endcase
  end

  // Output decodes the state register directly, so it is glitch-free and
  // lasts exactly one cycle: S12 never transitions to itself.
  assign det_o = (state == S12);

`ifdef SEQ_DET_CNT_EN
  // Count on the edge that enters S12, i.e. the same edge that raises det_o.
  logic cnt_inc;
  assign cnt_inc = (state_next == S12);

  seq_det_counter u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .cnt   (det_cnt_o)
  );
`endif

endmodule : day_12_sequence_detector

// File: tb/tb_day_12_sequence_detector.sv
// -----------------------------------------------------------------------------
// tb_day_12_sequence_detector
//   Self-checking bench for day_12_sequence_detector. Directed vectors with
//   hand-derived expectations, a long overlapping run for saturation, and a
//   randomized phase compared against a sliding-window reference model.
//   Define SEQ_DET_CNT_EN to also check det_cnt_o.
// -----------------------------------------------------------------------------
module tb_day_12_sequence_detector;

  localparam logic [11:0] PAT  = 12'b1110_1101_1011;
  localparam logic [9:0]  CONT = 10'b10_1101_1011;  // overlap continuation

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x_i = 1'b0;
  logic       det_o;
`ifdef SEQ_DET_CNT_EN
  logic [7:0] det_cnt_o;
`endif

  day_12_sequence_detector dut (
    .clk       (clk),
    .reset     (reset),
    .x_i       (x_i),
    .det_o     (det_o)
`ifdef SEQ_DET_CNT_EN
    ,
    .det_cnt_o (det_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the last 12 bits since reset, how many bits have been
  // seen, and a saturating count of matches.
  logic [11:0] m_win;
  int          m_valid;
  logic        m_det;
  int          m_cnt;

  typedef struct packed {
    logic rst;
    logic x;
    logic det;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One clock: drive on the falling edge, let the rising edge sample, then
  // advance the model so its outputs line up with the DUT's post-edge values.
  task automatic step(input logic r, input logic x);
    @(negedge clk);
    reset = r;
    x_i   = x;
    @(posedge clk);
    if (r) begin
      m_win   = '0;
      m_valid = 0;
      m_det   = 1'b0;
      m_cnt   = 0;
    end else begin
      m_win   = {m_win[10:0], x};
      m_valid = m_valid + 1;
      m_det   = (m_valid >= 12) && (m_win == PAT);
      if (m_det && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  // Append n bits (MSB first) expecting pulses on 1-based bit positions p1/p2.
  task automatic add_bits(input logic [31:0] bits, input int n, input int p1, input int p2);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.rst = 1'b0;
      v.x   = bits[n-1-i];
      v.det = ((i + 1) == p1) || ((i + 1) == p2);
      vecs.push_back(v);
    end
  endtask

  task automatic add_reset();
    vec_t v;
    v.rst = 1'b1;
    v.x   = 1'b1;
    v.det = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic feed_pattern();
    for (int i = 11; i >= 0; i--) step(1'b0, PAT[i]);
  endtask

  initial begin
    int pulses;
    logic [31:0] q_bits;
    int q_left;

    m_win = '0; m_valid = 0; m_det = 1'b0; m_cnt = 0;

    // Reset held for two edges with x_i toggling.
    step(1'b1, 1'b1);
    check("reset_hold_0", {31'd0, det_o}, 32'd0);
    step(1'b1, 1'b0);
    check("reset_hold_1", {31'd0, det_o}, 32'd0);
`ifdef SEQ_DET_CNT_EN
    check("reset_cnt", {24'd0, det_cnt_o}, 32'd0);
`endif

    // Directed table.
    add_bits(32'b0111_1010_1110_1101_1011_1, 21, 20, 0);  // embedded pattern
    add_reset();
    add_bits(32'b1110_1101_1011_1011_0110_11, 22, 12, 22); // overlap, 10 apart
    add_reset();
    add_bits(32'b1110_1101_1010, 12, 0, 0);                // near miss: last bit
    add_bits(32'b1111_1101_1011, 12, 0, 0);                // near miss: extra 1
    add_bits(32'b0, 12, 0, 0);
    add_reset();
    add_bits(32'b1110_1101_101, 11, 0, 0);                 // 11 bits, then reset
    add_reset();
    add_bits(32'b1, 1, 0, 0);                              // lone final bit
    add_bits(32'b1110_1101_1011, 12, 12, 0);               // full pattern

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].x);
      check($sformatf("vec%0d_det", i), {31'd0, det_o}, {31'd0, vecs[i].det});
    end

`ifdef SEQ_DET_CNT_EN
    // Three separate detections.
    step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      feed_pattern();
      step(1'b0, 1'b0);
    end
    check("cnt_three", {24'd0, det_cnt_o}, 32'd3);
`endif

    // 300 back-to-back overlapping detections.
    step(1'b1, 1'b0);
    pulses = 0;
    feed_pattern();
    pulses += det_o;
    for (int k = 0; k < 299; k++) begin
      for (int i = 9; i >= 0; i--) begin
        step(1'b0, CONT[i]);
        pulses += det_o;
      end
    end
    check("overlap_300_pulses", pulses, 32'd300);
`ifdef SEQ_DET_CNT_EN
    check("cnt_saturated", {24'd0, det_cnt_o}, 32'd255);
    for (int i = 9; i >= 0; i--) step(1'b0, CONT[i]);
    check("cnt_holds", {24'd0, det_cnt_o}, 32'd255);
    check("det_after_sat", {31'd0, det_o}, 32'd1);
    step(1'b1, 1'b0);
    check("cnt_cleared", {24'd0, det_cnt_o}, 32'd0);
`endif

    // Randomized phase against the reference model. Patterns are injected
    // often so detections, overlaps and near misses all occur.
    step(1'b1, 1'b0);
    q_left = 0;
    q_bits = '0;
    for (int c = 0; c < 4000; c++) begin
      logic r;
      logic x;
      r = ($urandom_range(0, 299) == 0);
      if (q_left == 0 && $urandom_range(0, 5) == 0) begin
        q_bits = {20'd0, PAT};
        if ($urandom_range(0, 3) == 0) q_bits[$urandom_range(0, 11)] ^= 1'b1;
        q_left = 12;
      end
      if (q_left > 0) begin
        x = q_bits[q_left-1];
        q_left--;
      end else begin
        x = $urandom_range(0, 1);
      end
      step(r, x);
      check("rand_det", {31'd0, det_o}, {31'd0, m_det});
`ifdef SEQ_DET_CNT_EN
      check("rand_cnt", {24'd0, det_cnt_o}, m_cnt);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_day_12_sequence_detector
